decision_thr_mc: RTL and testbench

Multi-channel, parametrised successor of the PBAS decision-threshold update. Each cycle it takes CH pixels' thresholds R(x) and applies the PBAS rule:
- R·(1−Rinc) if R > dmin·Rscale, else R·(1+Rinc).
- Result clamped to Rlow and to a configurable ceiling.

It sits in the PBAS pipeline after the distance/dmin stage and before the background-model write-back. It adds a pipeline enable, synchronous reset, a compile-time upper clamp and a per-frame clamp counter.

---
 rtl/dthr_pkg.sv | 24 ++
 rtl/dthr_lane.sv | 134 +++++++++++++
 rtl/decision_thr_mc.sv | 102 ++++++++++
 tb/tb_decision_thr_mc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dthr_pkg.sv
// Shared constants, types and helpers for the PBAS decision-threshold update.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dthr_pkg;

    // Single-cycle stages that follow the two multiplier pipelines
    localparam int LAT_CMP = 1;
    localparam int LAT_MUX = 1;
    localparam int LAT_SAT = 1;
    localparam int LAT_OUT = 1;

    // Which stage-F branch produced a lane result
    typedef enum logic [1:0] {
        DTHR_PASS = 2'd0,
        DTHR_LOW  = 2'd1,
        DTHR_HIGH = 2'd2
    } dthr_clamp_e;

    // rv -> rnv latency in enabled cycles for a given multiplier depth
    function automatic int dthr_lat(input int mul_lat);
        return 2 * mul_lat + LAT_CMP + LAT_MUX + LAT_SAT + LAT_OUT;
    endfunction

endpackage

// File: rtl/dthr_lane.sv
// One lane of the threshold update: thr=dmin*rscale, compare, factor select, rx*f, clamp, output reg.
// Latency: 2*MUL_LAT+4 enabled cycles from rx_i to rnx_o/clamp_o.
// Backpressure: none; ce=0 freezes every register. Upper clamp by rhigh_i only with DTHR_RHIGH_EN.
module dthr_lane #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [DATA_W-1:0] rx_i,
    input  logic [DATA_W-1:0] dmin_i,
    input  logic [DATA_W-1:0] rscale_i,
    input  logic [DATA_W-1:0] rlow_i,
    input  logic [DATA_W-1:0] one_minus_rinc_i,
    input  logic [DATA_W-1:0] one_plus_rinc_i,
`ifdef DTHR_RHIGH_EN
    input  logic [DATA_W-1:0] rhigh_i,
`endif
    output logic [DATA_W-1:0] rnx_o,
    output logic              clamp_o
);
    import dthr_pkg::*;

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]     thr_q [MUL_LAT];
    logic [DATA_W-1:0] rxa_q [MUL_LAT];
    logic              dec_q;
    logic [DATA_W-1:0] rxb_q;
    logic [DATA_W-1:0] rxc_q;
    logic [DATA_W-1:0] f_q;
    logic [PW-1:0]     p_q [MUL_LAT];
    logic [DATA_W-1:0] res_d, res_q;
    dthr_clamp_e       cls_d, cls_q;
    logic [DATA_W-1:0] rnx_q;
    logic              clamp_q;

    logic [PW-1:0]     rx_ext;
    logic [DATA_W:0]   win;
    logic              lo;
    logic              ovf;
    logic [DATA_W-1:0] q_v;
    logic [DATA_W-1:0] ceil_v;

    // rx aligned to the fixed-point position of thr for a full-width compare
    assign rx_ext = PW'(rxa_q[MUL_LAT-1]) << FRAC_W;

    // Stage A: dmin*rscale multiplier pipeline, rx delayed alongside
    always_ff @(posedge clk) begin
        if (ce) begin
            thr_q[0] <= PW'(dmin_i) * PW'(rscale_i);
            rxa_q[0] <= rx_i;
            for (int k = 1; k < MUL_LAT; k++) begin
                thr_q[k] <= thr_q[k-1];
                rxa_q[k] <= rxa_q[k-1];
            end
        end
    end

    // Stages B and C: strict compare (equality increases), then factor select
    always_ff @(posedge clk) begin
        if (ce) begin
            dec_q <= (rx_ext > thr_q[MUL_LAT-1]);
            rxb_q <= rxa_q[MUL_LAT-1];
            f_q   <= dec_q ? one_minus_rinc_i : one_plus_rinc_i;
            rxc_q <= rxb_q;
        end
    end

    // Stage D: rx*f multiplier pipeline
    always_ff @(posedge clk) begin
        if (ce) begin
            p_q[0] <= PW'(rxc_q) * PW'(f_q);
            for (int k = 1; k < MUL_LAT; k++) begin
                p_q[k] <= p_q[k-1];
            end
        end
    end

    assign win = p_q[MUL_LAT-1][DATA_W+FRAC_W:FRAC_W];
    assign ovf = |p_q[MUL_LAT-1][PW-1:DATA_W+FRAC_W];
    assign q_v = p_q[MUL_LAT-1][FRAC_W +: DATA_W];
    assign lo  = (win < {1'b0, rlow_i});

`ifdef DTHR_RHIGH_EN
    // A floor above the ceiling keeps the floor: results never drop below rlow
    assign ceil_v = (rlow_i > rhigh_i) ? rlow_i : rhigh_i;
`else
    assign ceil_v = '1;
`endif

    // Stages E/F: truncate, then clamp with floor taking priority over ceiling
    always_comb begin
        res_d = q_v;
        cls_d = DTHR_PASS;
        if (lo) begin
            res_d = rlow_i;
            cls_d = DTHR_LOW;
        end else if (ovf) begin
            res_d = ceil_v;
            cls_d = DTHR_HIGH;
`ifdef DTHR_RHIGH_EN
        end else if (q_v > ceil_v) begin
            res_d = ceil_v;
            cls_d = DTHR_HIGH;
`endif
        end
    end

    // Saturation result register
    always_ff @(posedge clk) begin
        if (ce) begin
            res_q <= res_d;
            cls_q <= cls_d;
        end
    end

    // Output register, cleared by reset so rnx reads zero until the first beat
    always_ff @(posedge clk) begin
        if (rst) begin
            rnx_q   <= '0;
            clamp_q <= 1'b0;
        end else if (ce) begin
            rnx_q   <= res_q;
            clamp_q <= (cls_q != DTHR_PASS);
        end
    end

    assign rnx_o   = rnx_q;
    assign clamp_o = clamp_q;

endmodule

// File: rtl/decision_thr_mc.sv
// CH-lane PBAS decision-threshold update with valid tracking and a per-frame clamp counter.
// Latency: LAT = 2*MUL_LAT+4 enabled cycles rv->rnv; clamp_cnt one cycle after the counted beat.
// Backpressure: none beyond ce (ce=0 freezes all stages and forces rnv=0). DTHR_RHIGH_EN adds rhigh.
module decision_thr_mc #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int CH      = 1,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 rv,
    input  logic [CH*DATA_W-1:0] rx,
    input  logic [CH*DATA_W-1:0] dmin,
    input  logic [DATA_W-1:0]    rscale,
    input  logic [DATA_W-1:0]    rlow,
    input  logic [DATA_W-1:0]    one_minus_rinc,
    input  logic [DATA_W-1:0]    one_plus_rinc,
`ifdef DTHR_RHIGH_EN
    input  logic [DATA_W-1:0]    rhigh,
`endif
    input  logic                 frame_start,
    output logic                 rnv,
    output logic [CH*DATA_W-1:0] rnx,
    output logic [CNT_W-1:0]     clamp_cnt
);
    import dthr_pkg::*;

    localparam int LAT  = dthr_lat(MUL_LAT);
    localparam int PC_W = $clog2(CH + 1);

    logic [LAT-1:0]   vld_q;
    logic [CH-1:0]    clamp_v;
    logic [PC_W-1:0]  pop_d;
    logic [CNT_W:0]   sum_d;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        dthr_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .MUL_LAT(MUL_LAT)
        ) u_lane (
            .clk             (clk),
            .rst             (rst),
            .ce              (ce),
            .rx_i            (rx[i*DATA_W +: DATA_W]),
            .dmin_i          (dmin[i*DATA_W +: DATA_W]),
            .rscale_i        (rscale),
            .rlow_i          (rlow),
            .one_minus_rinc_i(one_minus_rinc),
            .one_plus_rinc_i (one_plus_rinc),
`ifdef DTHR_RHIGH_EN
            .rhigh_i         (rhigh),
`endif
            .rnx_o           (rnx[i*DATA_W +: DATA_W]),
            .clamp_o         (clamp_v[i])
        );
    end

    // Valid shift register matching the lane pipeline depth
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (ce) begin
            vld_q <= {vld_q[LAT-2:0], rv};
        end
    end

    // A beat is only delivered on an enabled cycle; stalled beats reappear once ce returns
    assign rnv = vld_q[LAT-1] & ce;

    // Count clamped lanes of the delivered beat and compute the next counter value
    always_comb begin
        pop_d = '0;
        for (int i = 0; i < CH; i++) begin
            pop_d = pop_d + PC_W'(clamp_v[i]);
        end
        sum_d = {1'b0, cnt_q} + (CNT_W+1)'(pop_d);
        cnt_d = cnt_q;
        if (frame_start) begin
            // a beat coinciding with frame_start belongs to the new frame
            cnt_d = rnv ? CNT_W'(pop_d) : '0;
        end else if (rnv) begin
            cnt_d = sum_d[CNT_W] ? '1 : sum_d[CNT_W-1:0];
        end
    end

    // Clamp counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clamp_cnt = cnt_q;

endmodule

// File: tb/tb_decision_thr_mc.sv
// Bench for decision_thr_mc at CH=4, MUL_LAT=4: directed vectors plus a per-cycle reference model.
// Latency expectation: 12 enabled cycles rv->rnv.
// Stalls, mid-stream reset and frame_start are exercised against the model and literal values.
module tb_decision_thr_mc;

    localparam int DW  = 16;
    localparam int FW  = 8;
    localparam int CH  = 4;
    localparam int ML  = 4;
    localparam int CW  = 24;
    localparam int LAT = 12;
`ifdef DTHR_RHIGH_EN
    localparam bit RH_EN = 1'b1;
`else
    localparam bit RH_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, ce, rv, frame_start;
    logic [CH*DW-1:0] rx, dmin;
    logic [DW-1:0]  rscale, rlow, one_minus_rinc, one_plus_rinc, rhigh;
    logic           rnv;
    logic [CH*DW-1:0] rnx;
    logic [CW-1:0]  clamp_cnt;

    always #5 clk = ~clk;

    decision_thr_mc #(
        .DATA_W(DW), .FRAC_W(FW), .CH(CH), .MUL_LAT(ML), .CNT_W(CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .rv            (rv),
        .rx            (rx),
        .dmin          (dmin),
        .rscale        (rscale),
        .rlow          (rlow),
        .one_minus_rinc(one_minus_rinc),
        .one_plus_rinc (one_plus_rinc),
`ifdef DTHR_RHIGH_EN
        .rhigh         (rhigh),
`endif
        .frame_start   (frame_start),
        .rnv           (rnv),
        .rnx           (rnx),
        .clamp_cnt     (clamp_cnt)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [CH*DW-1:0] dat;
        int               ncl;
        int               due;
    } beat_t;

    beat_t         mq[$];
    int            en_done  = 0;
    logic [CW-1:0] m_cnt    = '0;
    bit            pend_vld = 1'b0;
    int            pend_ncl = 0;
    bit            mon_en   = 1'b0;

    // One lane per the PBAS rule: {clamped, value}
    function automatic logic [16:0] ref_lane(input logic [15:0] r, d, rs, rl, om, op, rh);
        logic [63:0] thr, rext, p, win, q, lo64, ceil;
        thr  = {48'b0, d} * {48'b0, rs};
        rext = {48'b0, r} << FW;
        p    = {48'b0, r} * {48'b0, ((rext > thr) ? om : op)};
        win  = (p >> FW) & 64'h1FFFF;
        q    = (p >> FW) & 64'hFFFF;
        lo64 = {48'b0, rl};
        ceil = RH_EN ? ((rl > rh) ? lo64 : {48'b0, rh}) : 64'hFFFF;
        if (win < lo64) return {1'b1, rl};
        if ((p >> (DW + FW)) != 64'd0) return {1'b1, ceil[15:0]};
        if (q > ceil) return {1'b1, ceil[15:0]};
        return {1'b0, q[15:0]};
    endfunction

    function automatic beat_t ref_beat(input logic [CH*DW-1:0] rxv, dmv,
                                       input logic [15:0] rs, rl, om, op, rh);
        beat_t       b;
        logic [16:0] res;
        b.ncl = 0;
        b.due = 0;
        b.dat = '0;
        for (int i = 0; i < CH; i++) begin
            res = ref_lane(rxv[i*DW +: DW], dmv[i*DW +: DW], rs, rl, om, op, rh);
            b.dat[i*DW +: DW] = res[15:0];
            b.ncl += int'(res[16]);
        end
        return b;
    endfunction

    // Model state update at each active edge
    always @(posedge clk) begin
        beat_t       b;
        logic [63:0] tmp;
        if (rst) begin
            mq.delete();
            m_cnt = '0;
        end else begin
            if (frame_start) m_cnt = pend_vld ? CW'(pend_ncl) : '0;
            else if (pend_vld) begin
                tmp   = {40'b0, m_cnt} + 64'(pend_ncl);
                m_cnt = (tmp > 64'hFFFFFF) ? '1 : tmp[CW-1:0];
            end
            if (ce) begin
                en_done++;
                if (rv) begin
                    b     = ref_beat(rx, dmin, rscale, rlow, one_minus_rinc, one_plus_rinc, rhigh);
                    b.due = en_done + LAT - 1;
                    mq.push_back(b);
                end
            end
        end
        pend_vld = 1'b0;
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        bit ev;
        if (mon_en) begin
            ev = ce && (mq.size() != 0) && (mq[0].due == en_done);
            chk("rnv", {63'b0, rnv}, {63'b0, ev});
            if (ev) begin
                chk("rnx", rnx, mq[0].dat);
                pend_vld = 1'b1;
                pend_ncl = mq[0].ncl;
                void'(mq.pop_front());
            end
            chk("clamp_cnt", {40'b0, clamp_cnt}, {40'b0, m_cnt});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_rnv(output int k);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            rv = 1'b0;
            if (rnv) begin
                k = c;
                break;
            end
        end
    endtask

    task automatic run_one(input string nm, input logic [15:0] r, d, rs, rl, om, op, rh,
                           input logic [15:0] exp_val, input int exp_inc);
        int            lat;
        logic [CW-1:0] c0;
        rscale = rs; rlow = rl; one_minus_rinc = om; one_plus_rinc = op; rhigh = rh;
        rx = {CH{r}};
        dmin = {CH{d}};
        c0 = clamp_cnt;
        rv = 1'b1;
        wait_rnv(lat);
        chk({nm, "_lat"}, 64'(lat), 64'(LAT));
        chk({nm, "_rnx"}, rnx, {CH{exp_val}});
        @(posedge clk); #1;
        chk({nm, "_cnt"}, {40'b0, clamp_cnt}, {40'b0, c0} + 64'(exp_inc));
    endtask

    initial begin
        int               lat;
        logic [CH*DW-1:0] hold, trx, tdm;
        logic [CW-1:0]    c0;

        rst = 1'b1; ce = 1'b1; rv = 1'b0; frame_start = 1'b0;
        rx = '0; dmin = '0;
        rscale = 16'h0500; rlow = 16'h0100;
        one_minus_rinc = 16'h00F0; one_plus_rinc = 16'h0110; rhigh = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_rnv", {63'b0, rnv}, 64'd0);
        chk("reset_rnx", rnx, 64'd0);
        chk("reset_cnt", {40'b0, clamp_cnt}, 64'd0);

        run_one("inc",   16'h1000, 16'h0A00, 16'h0500, 16'h0100, 16'h00F0, 16'h0110, 16'hFFFF, 16'h1100, 0);
        run_one("dec",   16'h4000, 16'h0A00, 16'h0500, 16'h0100, 16'h00F0, 16'h0110, 16'hFFFF, 16'h3C00, 0);
        run_one("equal", 16'h3200, 16'h0A00, 16'h0500, 16'h0100, 16'h00F0, 16'h0110, 16'hFFFF, 16'h3520, 0);
        run_one("rlow",  16'h1000, 16'h0100, 16'h0100, 16'h1200, 16'h00F0, 16'h0110, 16'hFFFF, 16'h1200, 4);
        run_one("ovf",   16'hF000, 16'hFF00, 16'hFF00, 16'h0100, 16'h00F0, 16'h0200, 16'h8000,
                RH_EN ? 16'h8000 : 16'hFFFF, 4);

        // Continuous stream with a 3-cycle stall and a mid-stream reset
        rscale = 16'h0500; rlow = 16'h0800; one_minus_rinc = 16'h00F0;
        one_plus_rinc = 16'h0110; rhigh = 16'hC000;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < CH; i++) begin
                trx[i*DW +: DW] = 16'(16'h0400 + k * 16'h0700 + i * 16'h0D00);
                tdm[i*DW +: DW] = 16'(16'h0600 + i * 16'h0400);
            end
            rx = trx; dmin = tdm; rv = 1'b1;
            @(posedge clk); #1;
            if (k == 10) begin
                ce = 1'b0;
                hold = rnx;
                repeat (3) @(posedge clk);
                #1;
                chk("stall_rnx_hold", rnx, hold);
                ce = 1'b1;
            end
            if (k == 20) begin
                rv = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("midrst_rnv", {63'b0, rnv}, 64'd0);
                chk("midrst_cnt", {40'b0, clamp_cnt}, 64'd0);
            end
        end
        rv = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;

        // Beat clamping lanes 0 and 1, first counted normally, then with frame_start
        rscale = 16'h0100; rlow = 16'h1200; one_minus_rinc = 16'h00F0;
        one_plus_rinc = 16'h0110; rhigh = 16'hFFFF;
        trx = {16'h2000, 16'h4000, 16'h1000, 16'h1000};
        tdm = {16'h4000, 16'h0100, 16'h0100, 16'h0100};
        rx = trx; dmin = tdm;
        c0 = clamp_cnt;
        rv = 1'b1;
        wait_rnv(lat);
        chk("two_clamp_lat", 64'(lat), 64'(LAT));
        chk("two_clamp_rnx", rnx, 64'h2200_3C00_1200_1200);
        @(posedge clk); #1;
        chk("two_clamp_cnt", {40'b0, clamp_cnt}, {40'b0, c0} + 64'd2);

        rv = 1'b1;
        wait_rnv(lat);
        chk("frame_beat_lat", 64'(lat), 64'(LAT));
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("frame_beat_cnt", {40'b0, clamp_cnt}, 64'd2);

        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("frame_alone_cnt", {40'b0, clamp_cnt}, 64'd0);

        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
